// File: rtl/timer_capture_alarm_if.sv
// Timer interface bundle: level controls and alarm value from the bench side,
// registered count/capture/pulse outputs from the timer side.
interface timer_capture_alarm_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             stop;
    logic             capture;
    logic             rst_capture;
    logic             alarm_en;
    logic [WIDTH-1:0] alarm;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] captured;
    logic             alarm_out;
    logic             wrap_out;
    logic             running;

    modport master (
        output start, stop, capture, rst_capture, alarm_en, alarm,
        input  counter, captured, alarm_out, wrap_out, running
    );

    modport slave (
        input  start, stop, capture, rst_capture, alarm_en, alarm,
        output counter, captured, alarm_out, wrap_out, running
    );
endinterface

// File: rtl/timer_capture_alarm.sv
// Free-running capture/alarm timer: edge-detected start/capture/clear controls,
// RUN/HALT counting, one-cycle alarm and wrap pulses.
module timer_capture_alarm #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    timer_capture_alarm_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_counter;
    logic [WIDTH-1:0] r_captured;
    logic             r_alarmOut;
    logic             r_wrapOut;
    logic             r_start;
    logic             r_capture;
    logic             r_rstCapture;
    logic             w_startRise;
    logic             w_captureRise;
    logic             w_clearRise;
    logic             w_running;
    logic             w_increment;

    assign w_startRise   = bus.start & ~r_start;
    assign w_captureRise = bus.capture & ~r_capture;
    assign w_clearRise   = bus.rst_capture & ~r_rstCapture;
    assign w_increment   = (r_state == RUN) & ~bus.stop & ~w_startRise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Start rise restarts from any state and beats stop; only a start rise leaves HALT.
    always_comb begin
        w_nextState = r_state;
        if (w_startRise) begin
            w_nextState = RUN;
        end else begin
            case (r_state)
                RUN:     w_nextState = bus.stop ? HALT : RUN;
                HALT:    w_nextState = HALT;
                IDLE:    w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        w_running = (r_state == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_counter    <= '0;
            r_captured   <= '0;
            r_alarmOut   <= 1'b0;
            r_wrapOut    <= 1'b0;
            r_start      <= 1'b0;
            r_capture    <= 1'b0;
            r_rstCapture <= 1'b0;
        end else begin
            r_start      <= bus.start;
            r_capture    <= bus.capture;
            r_rstCapture <= bus.rst_capture;

            if (w_startRise) begin
                r_counter <= '0;
            end else if (w_increment) begin
                r_counter <= r_counter + 1'b1;
            end

            // Clear beats a coincident capture; capture sees the pre-edge count.
            if (w_clearRise) begin
                r_captured <= '0;
            end else if (w_captureRise) begin
                r_captured <= r_counter;
            end

            r_alarmOut <= (r_state == RUN) & bus.alarm_en & (r_counter == bus.alarm) & ~w_startRise;
            r_wrapOut  <= w_increment & (r_counter == {WIDTH{1'b1}});
        end
    end

    assign bus.counter   = r_counter;
    assign bus.captured  = r_captured;
    assign bus.alarm_out = r_alarmOut;
    assign bus.wrap_out  = r_wrapOut;
    assign bus.running   = w_running;

endmodule

// File: doc/timer_capture_alarm.md
# timer_capture_alarm

Free-running capture/alarm timer that produces the `counter`, `captured` and `alarm_out` outputs checked by the timer scoreboard. It detects rising edges on `start`, `capture` and `rst_capture` and snapshots the running count. It raises a one-cycle alarm pulse when the count passes a programmable value. It sits behind `timer_bfm` as the DUT end of the timer interface. All behaviour is synchronous to `clk`.

## Interface
- `WIDTH`, default 32: counter, capture and alarm width.
- `clk`  in  1  clock; everything samples on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level; a rising edge restarts counting from 0.
- `stop`  in  1  level; while high in RUN, the counter freezes.
- `capture`  in  1  level; a rising edge snapshots the counter.
- `rst_capture`  in  1  level; a rising edge clears `captured`.
- `alarm_en`  in  1  enables alarm compare.
- `alarm`  in  WIDTH  alarm compare value.
- `counter`  out  WIDTH  running count, registered.
- `captured`  out  WIDTH  last snapshot, registered.
- `alarm_out`  out  1  one-cycle alarm pulse, registered.
- `wrap_out`  out  1  one-cycle pulse on counter wrap, registered.
- `running`  out  1  high while the state is RUN.

## Operation
- Edge detect: each of `start`, `capture` and `rst_capture` has a previous-value register `*_r`.
  - A rise is `x & !x_r`, evaluated on the current sampled input.
  - Each `*_r` register loads the input every edge.
- States:
  - IDLE (reset): counter holds 0.
  - RUN: counter increments by 1 every edge.
  - HALT: counter holds its value.
- Transitions:
  - From any state, a start rise goes to RUN with `counter <= 0`. This takes precedence over `stop`.
  - RUN with `stop`=1 goes to HALT; the counter holds at that edge.
  - HALT with `stop`=0 and no start rise stays in HALT. Only a start rise leaves HALT.
  - RUN with `stop`=0 stays in RUN and increments.
- Wrap: in RUN, a counter of all ones goes to 0 and sets `wrap_out`=1 for the following cycle.
- Capture: on a capture rise, `captured <= counter`, using the pre-edge counter value.
  - Capture operates in every state.
- Clear: on an rst_capture rise, `captured <= 0`. If it coincides with a capture rise, the clear wins.
- Alarm: at an edge where state is RUN, `alarm_en`=1, `counter == alarm` and no start rise occurs, `alarm_out` is 1 for the next cycle.
  - Otherwise `alarm_out` is 0.
  - Consequence: while `alarm_out`=1, `counter == alarm+1` (mod 2^WIDTH).
  - There is no alarm in IDLE or HALT, even if `counter == alarm`.
- Arithmetic: all arithmetic is unsigned modulo 2^WIDTH. There is no saturation.

## Timing
- Reset (`rst_n`=0 at an edge) overrides every other input. The following take effect at that edge:
  - `counter`=0, `captured`=0, `alarm_out`=0, `wrap_out`=0, `running`=0.
  - State = IDLE.
  - All `*_r` registers = 0.
- After reset is released, an input already high at the first edge counts as a rise.
- Reset mid-RUN: the count is lost; a new start rise is needed to resume.
- Start latency:
  - A rise is sampled at edge k, giving `counter`=0 and `running`=1 after edge k.
  - `counter`=n after edge k+n.
- Capture and clear latency: 1 edge; `captured` updates at the edge the rise is sampled.
- Alarm and wrap pulses:
  - Each is exactly 1 cycle wide.
  - Each is asserted after the edge on which the counter leaves the matching value.
- A held-high level produces exactly one event; a new event requires a low-then-high transition.
- A start rise on the same edge as `counter == alarm` gives no alarm and `counter <= 0`.

## Test plan
- Reset, then start rise at edge 10:
  - `counter` reads 0 after edge 10 and 25 after edge 35.
  - `running`=1.
- Start rise at edge 10, capture rise at edge 20:
  - `captured`=9 after edge 20 and holds 9 through edge 40.
  - Rst_capture rise at edge 40 gives `captured`=0.
- Simultaneous capture and rst_capture rises with counter=50:
  - `captured`=0.
- `alarm_en`=1, `alarm`=100, start rise at edge 0:
  - `alarm_out`=1 only in the cycle after edge 101, with `counter`=101.
  - With `alarm_en`=0, `alarm_out` stays 0.
- `stop`=1 at counter=30:
  - Counter holds 30 for 20 cycles and `running`=0.
  - `stop`=0 alone keeps 30.
  - A start rise gives 0, then counting resumes.
- Force wrap: start, then run to 2^WIDTH-1 (`WIDTH`=8 variant: 255):
  - Next edge gives `counter`=0 and `wrap_out`=1 for one cycle.
- `rst_n`=0 for 1 edge mid-RUN (counter=77, captured=40):
  - All outputs are 0 at that edge.
  - Counter stays 0 until the next start rise.
